// File: rtl/vec_pipe_pkg.sv
// vec_pipe_pkg: shared definitions for the vector execute/memory/writeback pipeline.
//   op_e       opcode encoding carried from the decoder
//   FIFO_REG   register-file address mapped to the input FIFO (never written)
//   writes_rd  true for opcodes that produce a register result
package vec_pipe_pkg;

  typedef enum logic [3:0] {
    OP_ADD   = 4'd0,
    OP_SUB   = 4'd1,
    OP_AND   = 4'd2,
    OP_OR    = 4'd3,
    OP_XOR   = 4'd4,
    OP_PASSB = 4'd5,
    OP_ADDI  = 4'd6,
    OP_LD    = 4'd7,
    OP_ST    = 4'd8,
    OP_JZ    = 4'd9
  } op_e;

  localparam int unsigned FIFO_REG = 0;

  function automatic logic writes_rd(input op_e op);
    return op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_PASSB, OP_ADDI, OP_LD};
  endfunction

endpackage

// File: rtl/vec_alu_lane.sv
// vec_alu_lane: one N-bit SIMD lane of the execute stage.
//   op   in  4  opcode (vec_pipe_pkg::op_e)
//   a    in  N  forwarded source A
//   b    in  N  forwarded source B
//   imm  in  N  broadcast immediate
//   y    out N  lane result, modulo 2^N (0 for LD/ST/JZ; LD data comes from RAM)
//   zf   out 1  source A is zero (used by JZ)
module vec_alu_lane
  import vec_pipe_pkg::*;
#(
  parameter int unsigned N = 32
) (
  input  logic [3:0]   op,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [N-1:0] imm,
  output logic [N-1:0] y,
  output logic         zf
);

  always_comb begin
    y = '0;
    case (op_e'(op))
      OP_ADD:   y = a + b;
      OP_SUB:   y = a - b;
      OP_AND:   y = a & b;
      OP_OR:    y = a | b;
      OP_XOR:   y = a ^ b;
      OP_PASSB: y = b;
      OP_ADDI:  y = a + imm;
      default:  y = '0;
    endcase
  end

  assign zf = (a == '0);

endmodule

// File: rtl/vec_pipe_hazard_core.sv
// vec_pipe_hazard_core: LANES-wide issue/execute/memory/writeback pipeline with
// 2-source forwarding, load-use and FIFO-empty stalls, lane write masks and JZ flush.
//   clk, rst                  clock, asynchronous active-high reset
//   in_valid/in_ready         issue handshake; in_op/in_mask/in_rd/in_rs/in_rt/in_imm/in_target
//   src_empty                 input FIFO (register 0) empty
//   rf_ra/rf_rb, rf_da/rf_db  combinational register-file read port
//   rf_we/rf_wa/rf_wd         writeback port (lane enables, address, data)
//   mem_addr/mem_we/mem_wd    data RAM port; mem_rd returns one cycle after mem_addr
//   jump_valid/jump_target    taken-JZ pulse and its target
module vec_pipe_hazard_core
  import vec_pipe_pkg::*;
#(
  parameter int unsigned LANES  = 8,
  parameter int unsigned N      = 32,
  parameter int unsigned WA_RF  = 8,
  parameter int unsigned MEM_WA = 8,
  parameter int unsigned IA     = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [3:0]           in_op,
  input  logic [LANES-1:0]     in_mask,
  input  logic [WA_RF-1:0]     in_rd,
  input  logic [WA_RF-1:0]     in_rs,
  input  logic [WA_RF-1:0]     in_rt,
  input  logic [N-1:0]         in_imm,
  input  logic [IA-1:0]        in_target,
  input  logic                 src_empty,
  output logic [WA_RF-1:0]     rf_ra,
  output logic [WA_RF-1:0]     rf_rb,
  input  logic [LANES*N-1:0]   rf_da,
  input  logic [LANES*N-1:0]   rf_db,
  output logic [LANES-1:0]     rf_we,
  output logic [WA_RF-1:0]     rf_wa,
  output logic [LANES*N-1:0]   rf_wd,
  output logic [MEM_WA-1:0]    mem_addr,
  output logic                 mem_we,
  output logic [LANES*N-1:0]   mem_wd,
  input  logic [LANES*N-1:0]   mem_rd,
  output logic                 jump_valid,
  output logic [IA-1:0]        jump_target
);

  localparam logic [WA_RF-1:0] FIFO_ADDR = WA_RF'(FIFO_REG);

  // Stage record types follow the module parameters, so they live here.
  typedef struct packed {
    logic                 valid;
    op_e                  op;
    logic [LANES-1:0]     mask;
    logic [WA_RF-1:0]     rd;
    logic [LANES*N-1:0]   a;
    logic [LANES*N-1:0]   b;
    logic [N-1:0]         imm;
    logic [IA-1:0]        target;
  } stage_t;

  typedef struct packed {
    logic                 valid;
    logic                 is_ld;
    logic [LANES-1:0]     wmask;
    logic [WA_RF-1:0]     rd;
    logic [LANES*N-1:0]   data;
  } mres_t;

  typedef struct packed {
    logic                 valid;
    logic [LANES-1:0]     wmask;
    logic [WA_RF-1:0]     rd;
    logic [LANES*N-1:0]   data;
  } wres_t;

  stage_t e;
  mres_t  m;
  wres_t  w;

  logic [LANES*N-1:0] e_res, m_res, fwd_a, fwd_b;
  logic [LANES-1:0]   e_zf, e_wm;
  logic               jump_taken, load_use, fifo_wait, accept;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    vec_alu_lane #(.N(N)) u_alu (
      .op  (e.op),
      .a   (e.a[l*N +: N]),
      .b   (e.b[l*N +: N]),
      .imm (e.imm),
      .y   (e_res[l*N +: N]),
      .zf  (e_zf[l])
    );
  end

  // Lanes the E instruction will actually write; register 0 never forwards.
  assign e_wm  = (e.valid && writes_rd(e.op) && e.rd != FIFO_ADDR) ? e.mask : '0;
  assign m_res = m.is_ld ? mem_rd : m.data;

  // Per-lane priority E > M > W > RF; a masked-off producer lane falls through.
  always_comb begin
    fwd_a = rf_da;
    fwd_b = rf_db;
    for (int unsigned l = 0; l < LANES; l++) begin
      if (e_wm[l] && e.rd == in_rs)        fwd_a[l*N +: N] = e_res[l*N +: N];
      else if (m.wmask[l] && m.rd == in_rs) fwd_a[l*N +: N] = m_res[l*N +: N];
      else if (w.wmask[l] && w.rd == in_rs) fwd_a[l*N +: N] = w.data[l*N +: N];
      if (e_wm[l] && e.rd == in_rt)        fwd_b[l*N +: N] = e_res[l*N +: N];
      else if (m.wmask[l] && m.rd == in_rt) fwd_b[l*N +: N] = m_res[l*N +: N];
      else if (w.wmask[l] && w.rd == in_rt) fwd_b[l*N +: N] = w.data[l*N +: N];
    end
  end

  // Taken when every enabled lane of A is zero; an empty mask is taken.
  assign jump_taken = e.valid && e.op == OP_JZ && (&(~e.mask | e_zf));
  assign load_use   = e.valid && e.op == OP_LD && e.rd != FIFO_ADDR &&
                      (e.rd == in_rs || e.rd == in_rt);
  assign fifo_wait  = (in_rs == FIFO_ADDR || in_rt == FIFO_ADDR) && src_empty;
  assign in_ready   = !rst && !load_use && !fifo_wait && !jump_taken;
  assign accept     = in_valid && in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      e <= '0;
      m <= '0;
      w <= '0;
    end else begin
      e <= '{valid: accept, op: op_e'(in_op), mask: in_mask, rd: in_rd,
             a: fwd_a, b: fwd_b, imm: in_imm, target: in_target};
      m <= '{valid: e.valid, is_ld: (e.op == OP_LD), wmask: e_wm, rd: e.rd, data: e_res};
      w <= '{valid: m.valid, wmask: m.wmask, rd: m.rd, data: m_res};
    end
  end

  assign rf_ra       = in_rs;
  assign rf_rb       = in_rt;
  assign rf_we       = (w.valid && w.rd != FIFO_ADDR) ? w.wmask : '0;
  assign rf_wa       = w.rd;
  assign rf_wd       = w.data;
  assign mem_addr    = MEM_WA'(e.target);
  assign mem_we      = e.valid && e.op == OP_ST;
  assign mem_wd      = e.a;
  assign jump_valid  = jump_taken;
  assign jump_target = jump_taken ? e.target : '0;

endmodule

// File: tb/tb_vec_pipe_hazard_core.sv
// Bench for vec_pipe_hazard_core: architectural (in-order, one-instruction-at-a-time)
// reference model with per-cycle output comparison, scripted scenarios and random traffic.
module tb_vec_pipe_hazard_core;
  import vec_pipe_pkg::*;

  localparam int unsigned LANES = 8, N = 32, WA_RF = 8, MEM_WA = 8, IA = 8;
  localparam int unsigned W = LANES * N;

  logic clk = 1'b0;
  logic rst;
  logic in_valid, in_ready, src_empty;
  logic [3:0] in_op;
  logic [LANES-1:0] in_mask, rf_we;
  logic [WA_RF-1:0] in_rd, in_rs, in_rt, rf_ra, rf_rb, rf_wa;
  logic [N-1:0] in_imm;
  logic [IA-1:0] in_target, jump_target;
  logic [W-1:0] rf_da, rf_db, rf_wd, mem_wd, mem_rd;
  logic [MEM_WA-1:0] mem_addr;
  logic mem_we, jump_valid;

  always #5 clk = ~clk;

  vec_pipe_hazard_core #(.LANES(LANES), .N(N), .WA_RF(WA_RF), .MEM_WA(MEM_WA), .IA(IA)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_mask(in_mask), .in_rd(in_rd), .in_rs(in_rs), .in_rt(in_rt), .in_imm(in_imm),
    .in_target(in_target), .src_empty(src_empty), .rf_ra(rf_ra), .rf_rb(rf_rb),
    .rf_da(rf_da), .rf_db(rf_db), .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wd(mem_wd), .mem_rd(mem_rd),
    .jump_valid(jump_valid), .jump_target(jump_target)
  );

  // Environment: physical RF/RAM updated from DUT ports; architectural copies from the model.
  logic [W-1:0] phys_rf [256];
  logic [W-1:0] phys_mem[256];
  logic [W-1:0] arch_rf [256];
  logic [W-1:0] arch_mem[256];
  logic [W-1:0] fifo_word;

  assign rf_da = (rf_ra == 8'd0) ? fifo_word : phys_rf[rf_ra];
  assign rf_db = (rf_rb == 8'd0) ? fifo_word : phys_rf[rf_rb];

  typedef struct {
    int unsigned acc;
    op_e         op;
    logic [7:0]  rd;
    logic [7:0]  we;
    logic [W-1:0] wd;
    logic        mw;
    logic [7:0]  maddr;
    logic [W-1:0] mwd;
    logic        jt;
    logic [7:0]  jtgt;
  } exp_t;

  exp_t pend[$];
  int unsigned total = 0, bad = 0, cyc = 0;
  int unsigned stall_cnt = 0, jv_cnt = 0, empty_left = 0;
  logic [7:0] last_jt;
  logic last_acc;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %h want %h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [W-1:0] lanemask(input logic [LANES-1:0] m);
    logic [W-1:0] v;
    for (int unsigned l = 0; l < LANES; l++) v[l*N +: N] = {N{m[l]}};
    return v;
  endfunction

  function automatic logic [W-1:0] bcast(input logic [N-1:0] x);
    return {LANES{x}};
  endfunction

  // Sequential-semantics execution of the instruction on the inputs right now.
  task automatic execute();
    exp_t x;
    op_e op;
    logic [W-1:0] a, b, res;
    logic [N-1:0] la, lb, r;
    logic wr, taken;
    op    = op_e'(in_op);
    a     = (in_rs == 8'd0) ? fifo_word : arch_rf[in_rs];
    b     = (in_rt == 8'd0) ? fifo_word : arch_rf[in_rt];
    taken = 1'b1;
    for (int unsigned l = 0; l < LANES; l++) begin
      la = a[l*N +: N];
      lb = b[l*N +: N];
      case (op)
        OP_ADD:   r = la + lb;
        OP_SUB:   r = la - lb;
        OP_AND:   r = la & lb;
        OP_OR:    r = la | lb;
        OP_XOR:   r = la ^ lb;
        OP_PASSB: r = lb;
        OP_ADDI:  r = la + in_imm;
        OP_LD:    r = arch_mem[in_target][l*N +: N];
        default:  r = '0;
      endcase
      res[l*N +: N] = r;
      if (in_mask[l] && la != '0) taken = 1'b0;
    end
    wr      = op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_PASSB, OP_ADDI, OP_LD};
    x.acc   = cyc;
    x.op    = op;
    x.rd    = in_rd;
    x.we    = (wr && in_rd != 8'd0) ? in_mask : 8'h00;
    x.wd    = res;
    x.mw    = (op == OP_ST);
    x.maddr = in_target;
    x.mwd   = a;
    x.jt    = (op == OP_JZ) && taken;
    x.jtgt  = in_target;
    for (int unsigned l = 0; l < LANES; l++)
      if (x.we[l]) arch_rf[in_rd][l*N +: N] = res[l*N +: N];
    if (x.mw) arch_mem[in_target] = a;
    pend.push_back(x);
  endtask

  // One clock cycle: compare at negedge, update model, then apply DUT side effects.
  task automatic step();
    exp_t e_ent, w_ent;
    bit has_e, has_w;
    logic ready_exp, exp_mw, exp_jv;
    logic [7:0] exp_we;
    logic [LANES-1:0] c_we;
    logic [7:0] c_wa, c_maddr;
    logic [W-1:0] c_wd, c_mwd;
    logic c_mw;
    has_e = 0;
    has_w = 0;
    @(negedge clk);
    foreach (pend[i]) begin
      if (pend[i].acc + 1 == cyc) begin e_ent = pend[i]; has_e = 1; end
      if (pend[i].acc + 3 == cyc) begin w_ent = pend[i]; has_w = 1; end
    end
    ready_exp = !((has_e && e_ent.jt) ||
                  (has_e && e_ent.op == OP_LD && e_ent.rd != 8'd0 &&
                   (e_ent.rd == in_rs || e_ent.rd == in_rt)) ||
                  ((in_rs == 8'd0 || in_rt == 8'd0) && src_empty));
    check("in_ready", W'(in_ready), W'(ready_exp));
    exp_we = has_w ? w_ent.we : 8'h00;
    check("rf_we", W'(rf_we), W'(exp_we));
    if (exp_we != 8'h00) begin
      check("rf_wa", W'(rf_wa), W'(w_ent.rd));
      check("rf_wd", rf_wd & lanemask(exp_we), w_ent.wd & lanemask(exp_we));
    end
    exp_mw = has_e && e_ent.mw;
    check("mem_we", W'(mem_we), W'(exp_mw));
    if (exp_mw) begin
      check("mem_addr", W'(mem_addr), W'(e_ent.maddr));
      check("mem_wd", mem_wd, e_ent.mwd);
    end
    exp_jv = has_e && e_ent.jt;
    check("jump_valid", W'(jump_valid), W'(exp_jv));
    if (exp_jv) check("jump_target", W'(jump_target), W'(e_ent.jtgt));
    if (!in_ready) stall_cnt++;
    if (jump_valid) begin jv_cnt++; last_jt = jump_target; end
    last_acc = in_valid && ready_exp;
    if (last_acc) execute();
    c_we = rf_we; c_wa = rf_wa; c_wd = rf_wd;
    c_mw = mem_we; c_maddr = mem_addr; c_mwd = mem_wd;
    @(posedge clk);
    #1;
    mem_rd = phys_mem[c_maddr];
    if (c_mw) phys_mem[c_maddr] = c_mwd;
    for (int unsigned l = 0; l < LANES; l++)
      if (c_we[l]) phys_rf[c_wa][l*N +: N] = c_wd[l*N +: N];
    while (pend.size() > 0 && pend[0].acc + 3 <= cyc) void'(pend.pop_front());
    cyc++;
    if (empty_left > 0) begin
      empty_left--;
      if (empty_left == 0) src_empty = 1'b0;
    end
  endtask

  task automatic issue(input op_e op, input logic [7:0] mask, input logic [7:0] rd,
                       input logic [7:0] rs, input logic [7:0] rt, input logic [7:0] tgt);
    int unsigned n;
    n = 0;
    in_op = op; in_mask = mask; in_rd = rd; in_rs = rs; in_rt = rt;
    in_imm = 32'd0; in_target = tgt; in_valid = 1'b1;
    do begin step(); n++; end while (!last_acc && n < 20);
    check("issue_accepted", W'(last_acc), W'(1'b1));
    in_valid = 1'b0;
  endtask

  task automatic drain(input int unsigned n);
    in_valid = 1'b0; in_rs = 8'd1; in_rt = 8'd1; src_empty = 1'b0;
    repeat (n) step();
  endtask

  task automatic set_reg(input logic [7:0] r, input logic [W-1:0] v);
    phys_rf[r] = v;
    arch_rf[r] = v;
  endtask

  task automatic reset_check();
    check("rst_in_ready", W'(in_ready), W'(1'b0));
    check("rst_rf_we", W'(rf_we), W'(8'h00));
    check("rst_mem_we", W'(mem_we), W'(1'b0));
    check("rst_jump_valid", W'(jump_valid), W'(1'b0));
    check("rst_jump_target", W'(jump_target), W'(8'h00));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_op = 4'd0; in_mask = 8'h00; in_rd = 8'd0;
    in_rs = 8'd1; in_rt = 8'd1; in_imm = 32'd0; in_target = 8'd0; src_empty = 1'b0;
    mem_rd = '0; fifo_word = bcast(32'd1000); last_jt = 8'h00; last_acc = 1'b0;
    for (int i = 0; i < 256; i++) begin
      logic [W-1:0] v, mv;
      for (int unsigned l = 0; l < LANES; l++) begin
        v[l*N +: N]  = $urandom;
        mv[l*N +: N] = $urandom;
      end
      phys_rf[i] = v; arch_rf[i] = v; phys_mem[i] = mv; arch_mem[i] = mv;
    end
    @(negedge clk);
    @(negedge clk);
    reset_check();
    @(posedge clk); #1;
    rst = 1'b0;

    // 1: back-to-back dependent ADDs
    set_reg(8'd2, bcast(32'd5));
    set_reg(8'd3, bcast(32'd7));
    stall_cnt = 0;
    issue(OP_ADD, 8'hFF, 8'd1, 8'd2, 8'd3, 8'd0);
    issue(OP_ADD, 8'hFF, 8'd4, 8'd1, 8'd1, 8'd0);
    check("t1_no_stall", W'(stall_cnt), W'(0));
    drain(5);
    check("t1_r4", phys_rf[4], bcast(32'd24));

    // 2: load-use
    phys_mem[3] = bcast(32'd11); arch_mem[3] = bcast(32'd11);
    issue(OP_LD, 8'hFF, 8'd5, 8'd1, 8'd1, 8'd3);
    stall_cnt = 0;
    issue(OP_ADD, 8'hFF, 8'd6, 8'd5, 8'd5, 8'd0);
    check("t2_one_stall", W'(stall_cnt), W'(1));
    drain(5);
    check("t2_r6", phys_rf[6], bcast(32'd22));

    // 3: partial write mask, dependent read merges new and old lanes
    set_reg(8'd8, bcast(32'd100));
    issue(OP_ADD, 8'h0F, 8'd8, 8'd2, 8'd3, 8'd0);
    issue(OP_ADD, 8'hFF, 8'd9, 8'd8, 8'd8, 8'd0);
    drain(5);
    check("t3_r8", phys_rf[8], {{4{32'd100}}, {4{32'd12}}});
    check("t3_r9", phys_rf[9], {{4{32'd200}}, {4{32'd24}}});

    // 4: taken JZ flushes the instruction presented in the jump cycle
    set_reg(8'd7, '0);
    set_reg(8'd10, bcast(32'd99));
    jv_cnt = 0;
    issue(OP_JZ, 8'hFF, 8'd0, 8'd7, 8'd7, 8'h40);
    in_op = OP_ADD; in_mask = 8'hFF; in_rd = 8'd10; in_rs = 8'd2; in_rt = 8'd3;
    in_valid = 1'b1;
    step();
    check("t4_flushed", W'(last_acc), W'(1'b0));
    drain(5);
    check("t4_jv_once", W'(jv_cnt), W'(1));
    check("t4_target", W'(last_jt), W'(8'h40));
    check("t4_r10", phys_rf[10], bcast(32'd99));

    // 5: FIFO empty for three cycles
    fifo_word = bcast(32'd1000);
    src_empty = 1'b1;
    empty_left = 3;
    stall_cnt = 0;
    issue(OP_ADD, 8'hFF, 8'd11, 8'd0, 8'd2, 8'd0);
    check("t5_three_stalls", W'(stall_cnt), W'(3));
    drain(5);
    check("t5_r11", phys_rf[11], bcast(32'd1005));

    // Random traffic over a small register/address window to provoke hazards
    for (int unsigned r = 1; r < 8; r++) begin
      logic [W-1:0] v;
      for (int unsigned l = 0; l < LANES; l++) v[l*N +: N] = $urandom_range(0, 2);
      set_reg(r[7:0], v);
    end
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      in_op     = 4'($urandom_range(0, 9));
      in_mask   = ($urandom_range(0, 1) == 1) ? 8'hFF : 8'($urandom);
      in_rd     = 8'($urandom_range(0, 7));
      in_rs     = 8'($urandom_range(0, 7));
      in_rt     = 8'($urandom_range(0, 7));
      in_imm    = $urandom_range(0, 3);
      in_target = 8'($urandom_range(0, 7));
      src_empty = ($urandom_range(0, 4) == 0);
      for (int unsigned l = 0; l < LANES; l++) fifo_word[l*N +: N] = $urandom_range(0, 2);
      step();
    end
    drain(5);

    // 6: reset while a LD is in M drops its write
    set_reg(8'd12, bcast(32'd77));
    issue(OP_LD, 8'hFF, 8'd12, 8'd1, 8'd1, 8'd3);
    step();
    rst = 1'b1;
    @(negedge clk);
    reset_check();
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 256; i++) begin
      arch_rf[i]  = phys_rf[i];
      arch_mem[i] = phys_mem[i];
    end
    pend.delete();
    drain(5);
    check("t6_r12", phys_rf[12], bcast(32'd77));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
